// File: rtl/riscv_defs.sv
// Shared definitions for the fetch stage.
//   RESET_PC / NOP     : reset fetch address and the bubble instruction
//   STALL_*            : bit positions in the stall vector
//   fetch_state_e      : fetch FSM encoding
//   ifid_ctrl_e        : IF/ID register update command
package riscv_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;  // addi x0,x0,0

  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUF  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_ctrl_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst          : clock, synchronous active-high reset
//   ctrl              : hold / bubble / load command for this cycle
//   pc_in, inst_in    : values captured on load (pc_in also used for bubbles)
//   id_pc_o, id_inst_o, id_valid_o : register contents presented to ID
module if_id_reg
  import riscv_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ifid_ctrl_e  ctrl,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_o    <= 32'h0;
      id_inst_o  <= NOP;
      id_valid_o <= 1'b0;
    end else begin
      unique case (ctrl)
        IFID_LOAD: begin
          id_pc_o    <= pc_in;
          id_inst_o  <= inst_in;
          id_valid_o <= 1'b1;
        end
        IFID_BUBBLE: begin
          id_pc_o    <= pc_in;
          id_inst_o  <= NOP;
          id_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry response buffer and
// the IF/ID register.
//   clk, rst                        : clock, synchronous active-high reset
//   stall[5:0]                      : bit0 holds PC, bit1 holds IF, bit2 holds ID
//   branch_flag_i, branch_target_i  : one-cycle redirect from ID
//   imem_req, imem_addr             : instruction memory request
//   imem_ready, imem_rdata          : same-cycle accept with data
//   id_pc_o, id_inst_o, id_valid_o  : IF/ID register outputs
//
// state  | meaning
// S_IDLE | one cycle after reset, no request
// S_REQ  | request outstanding at imem_addr
// S_BUF  | response captured in buffer, waiting for IF stall to clear
module fetch_stage
  import riscv_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic         drop, drop_n;
  logic [31:0]  drop_addr, drop_addr_n;
  logic [31:0]  fb_pc, fb_pc_n;
  logic [31:0]  fb_inst, fb_inst_n;
  ifid_ctrl_e   ifid_ctrl;
  logic [31:0]  ifid_pc, ifid_inst;
  logic         resp;
  logic         unused_stall;

  assign unused_stall = ^stall[5:3];

  // While a redirected request is still in flight the memory keeps the old
  // address; the PC already points at the branch target.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = drop ? drop_addr : pc;
  assign resp      = imem_req && imem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      drop_addr <= 32'h0;
      fb_pc     <= 32'h0;
      fb_inst   <= NOP;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop      <= drop_n;
      drop_addr <= drop_addr_n;
      fb_pc     <= fb_pc_n;
      fb_inst   <= fb_inst_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_n      = drop;
    drop_addr_n = drop_addr;
    fb_pc_n     = fb_pc;
    fb_inst_n   = fb_inst;
    ifid_ctrl   = stall[STALL_ID] ? IFID_HOLD : IFID_BUBBLE;
    ifid_pc     = pc;
    ifid_inst   = imem_rdata;

    unique case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (resp) begin
          if (drop) begin
            drop_n = 1'b0;
          end else if (!stall[STALL_IF]) begin
            ifid_ctrl = IFID_LOAD;
            if (!stall[STALL_PC]) pc_n = pc + 32'd4;
          end else begin
            fb_pc_n   = pc;
            fb_inst_n = imem_rdata;
            state_n   = S_BUF;
          end
        end
      end
      S_BUF: begin
        if (!stall[STALL_IF]) begin
          ifid_ctrl = IFID_LOAD;
          ifid_pc   = fb_pc;
          ifid_inst = fb_inst;
          pc_n      = pc + 32'd4;
          state_n   = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Redirect wins over everything. A request still waiting for acceptance
    // must have its eventual response thrown away; one accepted this cycle
    // is simply ignored.
    if (branch_flag_i) begin
      pc_n      = {branch_target_i[31:2], 2'b00};
      ifid_ctrl = IFID_BUBBLE;
      ifid_pc   = pc;
      state_n   = S_REQ;
      if (state == S_REQ && !imem_ready) begin
        drop_n = 1'b1;
        if (!drop) drop_addr_n = pc;
      end else begin
        drop_n = 1'b0;
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (ifid_ctrl),
    .pc_in      (ifid_pc),
    .inst_in    (ifid_inst),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_valid_o (id_valid_o)
  );

endmodule
